rv32i_mc_core: RTL

Multi-cycle, parametrised successor to the single-cycle RV32I core: same instruction-ROM and data-RAM port style, executed through a FETCH/DECODE/EXECUTE/MEM/WB state machine. Adds B-type branches, S-type stores, byte/half loads and stores with byte enables, a configurable reset PC and register count, a retire strobe, and a halt state on illegal or misaligned operations. It sits between the instruction ROM and the data RAM at the top of the SoC.

---
 rtl/rv32i_mc_core_if.sv | 28 ++
 rtl/rv32i_mc_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_core_if.sv
// Instruction-ROM / data-RAM bus of rv32i_mc_core.
// Optional feature macro: MEM_WAIT_EN adds the dataReady handshake from the data RAM.
interface rv32i_mc_core_if;
    logic [31:0] instrCode;
    logic [31:0] instrMemAddr;
    logic        dataWe;
    logic [31:0] dataAddr;
    logic [31:0] dataWData;
    logic [3:0]  dataBe;
    logic [31:0] dataRData;
`ifdef MEM_WAIT_EN
    logic        dataReady;

    modport master (input  instrCode, input  dataRData, input  dataReady,
                    output instrMemAddr, output dataWe, output dataAddr,
                    output dataWData, output dataBe);
    modport slave  (output instrCode, output dataRData, output dataReady,
                    input  instrMemAddr, input  dataWe, input  dataAddr,
                    input  dataWData, input  dataBe);
`else
    modport master (input  instrCode, input  dataRData,
                    output instrMemAddr, output dataWe, output dataAddr,
                    output dataWData, output dataBe);
    modport slave  (output instrCode, output dataRData,
                    input  instrMemAddr, input  dataWe, input  dataAddr,
                    input  dataWData, input  dataBe);
`endif
endinterface

// File: rtl/rv32i_mc_core.sv
// Multi-cycle RV32I/RV32E core: FETCH/DECODE/EXECUTE/MEM/WB with halt on faults.
// Optional feature macro: MEM_WAIT_EN (MEM stalls until dataReady).
module rv32i_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    rv32i_mc_core_if.master bus,
    output logic            retire,
    output logic            halt
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
    logic [XLEN-1:0] regs [NUM_REGS];

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    logic       is_r, is_i, is_ld, is_st, is_br;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_ld  = (opcode == OP_LD);
    assign is_st  = (opcode == OP_ST);
    assign is_br  = (opcode == OP_BR);
    assign bus.instrMemAddr = pc_q;

    logic mem_ready;
`ifdef MEM_WAIT_EN
    assign mem_ready = bus.dataReady;
`else
    assign mem_ready = 1'b1;
`endif

    logic            rs1_ok, rs2_ok, rd_ok, legal_c;
    logic [XLEN-1:0] imm_c, rs1_val_c, rs2_val_c;

    assign rs1_ok    = (32'(rs1) < NUM_REGS);
    assign rs2_ok    = (32'(rs2) < NUM_REGS);
    assign rd_ok     = (32'(rd) < NUM_REGS);
    assign rs1_val_c = (rs1 == 5'd0 || !rs1_ok) ? '0 : regs[rs1[RIDX_W-1:0]];
    assign rs2_val_c = (rs2 == 5'd0 || !rs2_ok) ? '0 : regs[rs2[RIDX_W-1:0]];

    // Decode: opcode/funct legality, register-index range, immediate format
    always_comb begin
        legal_c = 1'b0;
        imm_c   = {{20{ir_q[31]}}, ir_q[31:20]};
        case (opcode)
            OP_R:  legal_c = (f7 == 7'b0000000) ||
                             (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            OP_I: begin
                case (f3)
                    3'b001:  legal_c = (f7 == 7'b0000000);
                    3'b101:  legal_c = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    default: legal_c = 1'b1;
                endcase
            end
            OP_LD: legal_c = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            OP_ST: begin
                legal_c = !f3[2] && (f3[1:0] != 2'b11);
                imm_c   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            end
            OP_BR: begin
                legal_c = (f3[2:1] != 2'b01);
                imm_c   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            end
            default: legal_c = 1'b0;
        endcase
        if (!rs1_ok || ((is_r || is_st || is_br) && !rs2_ok) ||
            ((is_r || is_i || is_ld) && !rd_ok))
            legal_c = 1'b0;
    end

    logic [XLEN-1:0] op_b, alu_c, target_c, wdata_c, lane, load_c;
    logic [4:0]      shamt;
    logic [3:0]      be_c;
    logic            alt, taken_c, fault_c;

    // Execute: ALU, branch decision, alignment faults, store lane placement
    always_comb begin
        op_b     = (is_r || is_br) ? b_q : imm_q;
        shamt    = op_b[4:0];
        alt      = ir_q[30] && (is_r || f3 == 3'b101);
        alu_c    = a_q + op_b;
        taken_c  = 1'b0;
        fault_c  = 1'b0;
        be_c     = 4'b1111;
        wdata_c  = b_q;
        target_c = pc_q + imm_q;
        if (is_r || is_i) begin
            case (f3)
                3'b000:  alu_c = alt ? (a_q - op_b) : (a_q + op_b);
                3'b001:  alu_c = a_q << shamt;
                3'b010:  alu_c = XLEN'($signed(a_q) < $signed(op_b));
                3'b011:  alu_c = XLEN'(a_q < op_b);
                3'b100:  alu_c = a_q ^ op_b;
                3'b101:  alu_c = alt ? $unsigned($signed(a_q) >>> shamt) : (a_q >> shamt);
                3'b110:  alu_c = a_q | op_b;
                default: alu_c = a_q & op_b;
            endcase
        end
        case (f3)
            3'b000:  taken_c = (a_q == b_q);
            3'b001:  taken_c = (a_q != b_q);
            3'b100:  taken_c = ($signed(a_q) < $signed(b_q));
            3'b101:  taken_c = ($signed(a_q) >= $signed(b_q));
            3'b110:  taken_c = (a_q < b_q);
            3'b111:  taken_c = (a_q >= b_q);
            default: taken_c = 1'b0;
        endcase
        case (f3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << alu_c[1:0];
                wdata_c = {4{b_q[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << alu_c[1:0];
                wdata_c = {2{b_q[15:0]}};
            end
            default: ;
        endcase
        if (is_br && taken_c && target_c[1:0] != 2'b00)
            fault_c = 1'b1;
        if ((is_ld || is_st) && f3[1:0] == 2'b10 && alu_c[1:0] != 2'b00)
            fault_c = 1'b1;
        if ((is_ld || is_st) && f3[1:0] == 2'b01 && alu_c[0])
            fault_c = 1'b1;
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        lane = bus.dataRData >> {bus.dataAddr[1:0], 3'b000};
        case (f3)
            3'b000:  load_c = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_c = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_c = {24'b0, lane[7:0]};
            3'b101:  load_c = {16'b0, lane[15:0]};
            default: load_c = lane;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = legal_c ? S_EXECUTE : S_HALT;
            S_EXECUTE: begin
                if (fault_c)              state_d = S_HALT;
                else if (is_br)           state_d = S_FETCH;
                else if (is_ld || is_st)  state_d = S_MEM;
                else                      state_d = S_WB;
            end
            S_MEM:     if (mem_ready) state_d = is_ld ? S_WB : S_FETCH;
            S_WB:      state_d = S_FETCH;
            default:   state_d = S_HALT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Datapath registers, register file and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            imm_q         <= '0;
            alu_q         <= '0;
            mdr_q         <= '0;
            bus.dataWe    <= 1'b0;
            bus.dataBe    <= 4'b0000;
            bus.dataAddr  <= '0;
            bus.dataWData <= '0;
            retire        <= 1'b0;
            halt          <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[RIDX_W'(i)] <= '0;
        end else begin
            retire <= (state_d == S_FETCH) && (state_q != S_FETCH);
            halt   <= (state_d == S_HALT);
            case (state_q)
                S_FETCH:  ir_q <= bus.instrCode;
                S_DECODE: begin
                    a_q   <= rs1_val_c;
                    b_q   <= rs2_val_c;
                    imm_q <= imm_c;
                end
                S_EXECUTE: if (!fault_c) begin
                    alu_q <= alu_c;
                    pc_q  <= (is_br && taken_c) ? target_c : pc_q + 32'd4;
                    if (is_ld || is_st) bus.dataAddr <= alu_c;
                    if (is_st) begin
                        bus.dataWe    <= 1'b1;
                        bus.dataBe    <= be_c;
                        bus.dataWData <= wdata_c;
                    end
                end
                S_MEM: if (mem_ready) begin
                    bus.dataWe <= 1'b0;
                    bus.dataBe <= 4'b0000;
                    if (is_ld) mdr_q <= load_c;
                end
                S_WB: if (rd != 5'd0) regs[rd[RIDX_W-1:0]] <= is_ld ? mdr_q : alu_q;
                default: ;
            endcase
        end
    end
endmodule
